// File: rtl/sp_mem_ctrl_v2.sv
// sp_mem_ctrl_v2: parametrised single-port word memory behind a valid/ready
// request port, with a registered one-cycle response port.
//   - byte-enable writes, write-data loopback, out-of-range detection
//   - sticky error with explicit clear, hardware zeroing sweep after reset
// Optional feature macro: SPMEM_PARITY_EN adds one even-parity bit per word,
// a par_inj_i input that corrupts the stored parity on a write, and parity
// checking on reads.
//
// Handshake: a request is accepted on a rising clk edge where
// req_valid_i && req_ready_o. req_ready_o depends only on the controller
// state (never on req_valid_i). Every accepted request produces exactly one
// rsp_valid_o pulse in the following cycle. There is no response
// backpressure, so the consumer must take the response in that cycle.
module sp_mem_ctrl_v2 #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 5,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_wr_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [BE_WIDTH-1:0]   req_be_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  input  logic                  wr_loop_en_i,
  output logic [DATA_WIDTH-1:0] wr_loop_data_o,
  input  logic                  err_clr_i,
  output logic                  error_o,
`ifdef SPMEM_PARITY_EN
  input  logic                  par_inj_i,
`endif
  output logic [1:0]            state_o
);

  // Width of a word index inside the array.
  localparam int IDX_W = $clog2(DEPTH);
  // DEPTH expressed one bit wider than the address so DEPTH == 2**ADDR_WIDTH
  // still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX  = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  error_q, error_d;
  logic [DATA_WIDTH-1:0] wr_loop_q, wr_loop_d;

  // Storage array; not reset, the INIT sweep zeroes it instead.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  mem_we;
  logic [IDX_W-1:0]      mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic [IDX_W-1:0]      req_idx;
  logic                  in_range;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic                  rd_bad;

`ifdef SPMEM_PARITY_EN
  logic par_mem_q [DEPTH];
  logic mem_wpar;
`endif

  assign req_idx  = req_addr_i[IDX_W-1:0];
  assign in_range = ({1'b0, req_addr_i} < DEPTH_LIM);
  assign rd_word  = mem_q[req_idx];

`ifdef SPMEM_PARITY_EN
  // Stored parity bit must equal the XOR of the stored word (even parity).
  assign rd_bad = (par_mem_q[req_idx] != (^rd_word));
`else
  assign rd_bad = 1'b0;
`endif

  // Byte-merge the write data over the current word under the byte enables.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < BE_WIDTH; i++) begin
      if (req_be_i[i]) begin
        merged[8*i +: 8] = req_wdata_i[8*i +: 8];
      end
    end
  end

  // Controller state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, ready, response and memory write control.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    error_d     = error_q;
    wr_loop_d   = wr_loop_q;
    req_ready_o = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = cnt_q;
    mem_wdata   = '0;
`ifdef SPMEM_PARITY_EN
    mem_wpar    = 1'b0;
`endif

    case (state_q)
      ST_INIT: begin
        // Zero one word per cycle; leave after the last index.
        mem_we = 1'b1;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end

      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          rsp_valid_d = 1'b1;
          if (!in_range) begin
            // Faulting access: memory and read data stay untouched.
            rsp_err_d = 1'b1;
            error_d   = 1'b1;
            state_d   = ST_ERROR;
          end else if (req_wr_i) begin
            mem_we    = 1'b1;
            mem_waddr = req_idx;
            mem_wdata = merged;
`ifdef SPMEM_PARITY_EN
            mem_wpar  = (^merged) ^ par_inj_i;
`endif
            if (wr_loop_en_i) begin
              wr_loop_d = merged;
            end
          end else begin
            // Read data is returned even when its parity is bad.
            rsp_rdata_d = rd_word;
            if (rd_bad) begin
              rsp_err_d = 1'b1;
              error_d   = 1'b1;
              state_d   = ST_ERROR;
            end
          end
        end
      end

      ST_ERROR: begin
        if (err_clr_i) begin
          error_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
  end

  // Sweep counter, response and status registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      error_q     <= 1'b0;
      wr_loop_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      error_q     <= error_d;
      wr_loop_q   <= wr_loop_d;
    end
  end

  // Single write port into the data array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

`ifdef SPMEM_PARITY_EN
  // Parity bits share the data array's write port timing.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem_q[mem_waddr] <= mem_wpar;
    end
  end
`endif

  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_err_o      = rsp_err_q;
  assign rsp_rdata_o    = rsp_rdata_q;
  assign error_o        = error_q;
  assign wr_loop_data_o = wr_loop_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sp_mem_ctrl_v2.sv
// Testbench for sp_mem_ctrl_v2 (default parameters). A behavioural model
// (word array, init countdown, sticky error flag, expected-response queue)
// is stepped once per clock and compared against the DUT after every edge;
// scenario tasks add targeted checks of the documented cases.
module tb_sp_mem_ctrl_v2;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 5;
  localparam int BW    = DW / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic          req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [BW-1:0] req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          wr_loop_en;
  logic [DW-1:0] wr_loop_data;
  logic          err_clr;
  logic          error;
  logic [1:0]    state_dbg;
`ifdef SPMEM_PARITY_EN
  logic          par_inj;
`endif

  sp_mem_ctrl_v2 #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_wr_i       (req_wr),
    .req_addr_i     (req_addr),
    .req_wdata_i    (req_wdata),
    .req_be_i       (req_be),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .wr_loop_en_i   (wr_loop_en),
    .wr_loop_data_o (wr_loop_data),
    .err_clr_i      (err_clr),
    .error_o        (error),
`ifdef SPMEM_PARITY_EN
    .par_inj_i      (par_inj),
`endif
    .state_o        (state_dbg)
  );

  // ---------------- reference model ----------------
  int            n_checks = 0;
  int            n_pass   = 0;
  int            init_left;
  bit            m_err;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] m_loop;
  logic [DW:0]   exp_q [$];   // {err, rdata} per accepted request
`ifdef SPMEM_PARITY_EN
  bit            m_par [DEPTH];
`endif

  function automatic bit model_ready();
    return (init_left == 0) && !m_err;
  endfunction

  task automatic model_reset();
    init_left = DEPTH;
    m_err     = 1'b0;
    m_rdata   = '0;
    m_loop    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = '0;
`ifdef SPMEM_PARITY_EN
      m_par[i] = 1'b0;
`endif
    end
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic set_idle();
    req_valid  = 1'b0;
    req_wr     = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_be     = '0;
    wr_loop_en = 1'b0;
    err_clr    = 1'b0;
`ifdef SPMEM_PARITY_EN
    par_inj    = 1'b0;
`endif
  endtask

  task automatic drive(input bit wr, input int addr, input logic [DW-1:0] data,
                       input logic [BW-1:0] be);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = AW'(addr);
    req_wdata = data;
    req_be    = be;
  endtask

  // Advance the model over the coming edge, clock it, then score the DUT.
  task automatic tick();
    logic [DW-1:0] mask;
    logic [DW-1:0] w;
    logic [DW:0]   e;
    bit            bad;
    int            a;
    a = int'(req_addr);
    if (reset) begin
      if (init_left > 0) begin
        init_left--;
      end else if (m_err) begin
        if (err_clr) m_err = 1'b0;
      end else if (req_valid) begin
        if (a >= DEPTH) begin
          exp_q.push_back({1'b1, m_rdata});
          m_err = 1'b1;
        end else if (req_wr) begin
          mask = '0;
          for (int b = 0; b < BW; b++) mask[8*b +: 8] = {8{req_be[b]}};
          w = (m_mem[a] & ~mask) | (req_wdata & mask);
          m_mem[a] = w;
`ifdef SPMEM_PARITY_EN
          m_par[a] = (^w) ^ par_inj;
`endif
          if (wr_loop_en) m_loop = w;
          exp_q.push_back({1'b0, m_rdata});
        end else begin
          m_rdata = m_mem[a];
          bad = 1'b0;
`ifdef SPMEM_PARITY_EN
          bad = (m_par[a] != (^m_rdata));
`endif
          if (bad) m_err = 1'b1;
          exp_q.push_back({bad, m_rdata});
        end
      end
    end
    @(posedge clk);
    #1;
    // scoreboard
    n_checks++;
    if (req_ready !== model_ready())
      $display("FAIL sb_ready: got %0b want %0b", req_ready, model_ready());
    else n_pass++;
    n_checks++;
    if (error !== m_err) $display("FAIL sb_error: got %0b want %0b", error, m_err);
    else n_pass++;
    n_checks++;
    if (wr_loop_data !== m_loop)
      $display("FAIL sb_loop: got %h want %h", wr_loop_data, m_loop);
    else n_pass++;
    n_checks++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rsp_valid !== 1'b1 || rsp_err !== e[DW] || rsp_rdata !== e[DW-1:0])
        $display("FAIL sb_rsp: got v=%0b e=%0b d=%h want v=1 e=%0b d=%h",
                 rsp_valid, rsp_err, rsp_rdata, e[DW], e[DW-1:0]);
      else n_pass++;
    end else begin
      if (rsp_valid !== 1'b0) $display("FAIL sb_no_rsp: got rsp_valid=%0b want 0", rsp_valid);
      else n_pass++;
    end
    n_checks++;
    if (rsp_rdata !== m_rdata) $display("FAIL sb_rdata_hold: got %h want %h", rsp_rdata, m_rdata);
    else n_pass++;
  endtask

  // ---------------- scenarios ----------------
  task automatic wait_init_and_read_zero(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (req_ready !== 1'b0) $display("FAIL %s_init_ready: cycle %0d got %0b want 0", tag, i, req_ready);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL %s_ready_after_init: got %0b want 1", tag, req_ready);
    else n_pass++;
    for (int a = 0; a < DEPTH; a++) begin
      drive(1'b0, a, '0, '0);
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== '0)
        $display("FAIL %s_read_zero: addr %0d got v=%0b d=%h want v=1 d=0000", tag, a, rsp_valid, rsp_rdata);
      else n_pass++;
    end
    set_idle();
    tick();
  endtask

  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    model_reset();
    repeat (3) tick();
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, error} !== 4'b0 || rsp_rdata !== '0 || wr_loop_data !== '0)
      $display("FAIL reset_outputs: got rdy=%0b v=%0b e=%0b err=%0b d=%h loop=%h want all 0",
               req_ready, rsp_valid, rsp_err, error, rsp_rdata, wr_loop_data);
    else n_pass++;
    reset = 1'b1;
    wait_init_and_read_zero("reset");
  endtask

  task automatic test_byte_merge();
    drive(1'b1, 3, 16'hA5C3, 2'b11); tick();
    drive(1'b1, 3, 16'hFFFF, 2'b01); tick();
    drive(1'b0, 3, '0, '0);          tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'hA5FF)
      $display("FAIL merge_read: got v=%0b d=%h want v=1 d=a5ff", rsp_valid, rsp_rdata);
    else n_pass++;
    drive(1'b1, 3, 16'h0000, 2'b00); tick();   // be=0 leaves the word alone
    drive(1'b0, 3, '0, '0);          tick();
    n_checks++;
    if (rsp_rdata !== 16'hA5FF) $display("FAIL merge_be0: got %h want a5ff", rsp_rdata);
    else n_pass++;
    set_idle();
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) $display("FAIL merge_idle: got rsp_valid=%0b want 0", rsp_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr_loop_en = 1'b1;
    drive(1'b1, 7, 16'h1234, 2'b11); tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || wr_loop_data !== 16'h1234)
      $display("FAIL b2b_write: got v=%0b loop=%h want v=1 loop=1234", rsp_valid, wr_loop_data);
    else n_pass++;
    drive(1'b0, 7, '0, '0); tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h1234 || rsp_err !== 1'b0)
      $display("FAIL b2b_read: got v=%0b d=%h e=%0b want v=1 d=1234 e=0", rsp_valid, rsp_rdata, rsp_err);
    else n_pass++;
    set_idle();
    tick();
  endtask

  task automatic test_error();
    drive(1'b0, 20, '0, '0); tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || error !== 1'b1 || req_ready !== 1'b0)
      $display("FAIL err_oor_read: got v=%0b e=%0b err=%0b rdy=%0b want 1 1 1 0",
               rsp_valid, rsp_err, error, req_ready);
    else n_pass++;
    drive(1'b0, 0, '0, '0);    // requests while in ERROR are not taken
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (error !== 1'b1 || req_ready !== 1'b0 || rsp_valid !== 1'b0)
        $display("FAIL err_hold: cycle %0d got err=%0b rdy=%0b v=%0b want 1 0 0", i, error, req_ready, rsp_valid);
      else n_pass++;
    end
    set_idle();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    n_checks++;
    if (error !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL err_clear: got err=%0b rdy=%0b want 0 1", error, req_ready);
    else n_pass++;
    // first out-of-range address, as a write
    drive(1'b1, DEPTH, 16'hBEEF, 2'b11); tick();
    n_checks++;
    if (rsp_err !== 1'b1 || error !== 1'b1) $display("FAIL err_oor_write: got e=%0b err=%0b want 1 1", rsp_err, error);
    else n_pass++;
    set_idle();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    // the faulting write must not have aliased onto word 0
    drive(1'b0, 0, '0, '0); tick();
    n_checks++;
    if (rsp_rdata !== 16'h0000 || rsp_err !== 1'b0) $display("FAIL err_no_alias: got d=%h e=%0b want 0000 0", rsp_rdata, rsp_err);
    else n_pass++;
    // last in-range address, with err_clr asserted in IDLE (ignored)
    drive(1'b1, DEPTH - 1, 16'h5A5A, 2'b11); tick();
    err_clr = 1'b1;
    drive(1'b0, DEPTH - 1, '0, '0); tick();
    err_clr = 1'b0;
    n_checks++;
    if (rsp_rdata !== 16'h5A5A || rsp_err !== 1'b0 || error !== 1'b0 || req_ready !== 1'b1)
      $display("FAIL err_last_addr: got d=%h e=%0b err=%0b rdy=%0b want 5a5a 0 0 1",
               rsp_rdata, rsp_err, error, req_ready);
    else n_pass++;
    set_idle();
    tick();
  endtask

`ifdef SPMEM_PARITY_EN
  task automatic test_parity();
    drive(1'b1, 2, 16'h00FF, 2'b11);
    par_inj = 1'b1; tick(); par_inj = 1'b0;
    drive(1'b0, 2, '0, '0); tick();
    n_checks++;
    if (rsp_rdata !== 16'h00FF || rsp_err !== 1'b1 || error !== 1'b1)
      $display("FAIL parity_bad: got d=%h e=%0b err=%0b want 00ff 1 1", rsp_rdata, rsp_err, error);
    else n_pass++;
    set_idle();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 3) != 0);
      req_wr     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 11) == 0) req_addr = AW'($urandom_range(DEPTH, 31));
      else                            req_addr = AW'($urandom_range(0, DEPTH - 1));
      req_wdata  = DW'($urandom);
      req_be     = BW'($urandom_range(0, 3));
      wr_loop_en = 1'($urandom_range(0, 1));
      err_clr    = ($urandom_range(0, 3) == 0);
`ifdef SPMEM_PARITY_EN
      par_inj    = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    set_idle();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    wr_loop_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, int'($urandom_range(0, DEPTH - 1)), DW'($urandom) | 16'h0001, 2'b11);
      tick();
    end
    // a write response is now pending; reset must drop everything at once
    reset = 1'b0;
    #1;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_err, error} !== 4'b0 || rsp_rdata !== '0 || wr_loop_data !== '0)
      $display("FAIL midreset_outputs: got rdy=%0b v=%0b e=%0b err=%0b d=%h loop=%h want all 0",
               req_ready, rsp_valid, rsp_err, error, rsp_rdata, wr_loop_data);
    else n_pass++;
    model_reset();
    set_idle();
    tick();
    tick();
    reset = 1'b1;
    wait_init_and_read_zero("midreset");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_byte_merge();
    test_back_to_back();
    test_error();
`ifdef SPMEM_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
